// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS test-signal source producing 10-bit offset-binary DAC
// samples at the clk_256k rate. The output frequency is set in whole kHz.
// New configs are taken over valid/ready and are applied at a phase wrap,
// so the output never jumps mid-period.
module dds_wave_gen #(
  parameter int PHASE_W  = 24,
  parameter int FREQ_MAX = 100
) (
  input  logic       clk_256k,
  input  logic       rst_n,
  input  logic       en,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_freq,
  input  logic [1:0] cfg_wave,
  input  logic [1:0] cfg_amp,
  output logic       cfg_err,
  output logic [7:0] active_freq,
  output logic [9:0] dac_data,
  output logic       dac_valid
);

  localparam int         STAGES = 3;
  localparam logic [7:0] FMAX   = 8'(FREQ_MAX);

  localparam logic [1:0] W_SINE = 2'd0;
  localparam logic [1:0] W_SQR  = 2'd1;
  localparam logic [1:0] W_TRI  = 2'd2;

  // Quarter-wave magnitude table, sampled at bin centres: round(511*sin(pi/2*(i+0.5)/64)).
  localparam logic [8:0] SINE_ROM [64] = '{
    9'd6,   9'd19,  9'd31,  9'd44,  9'd56,  9'd69,  9'd81,  9'd94,
    9'd106, 9'd118, 9'd130, 9'd142, 9'd154, 9'd166, 9'd178, 9'd190,
    9'd201, 9'd213, 9'd224, 9'd235, 9'd246, 9'd257, 9'd268, 9'd279,
    9'd289, 9'd299, 9'd309, 9'd319, 9'd329, 9'd338, 9'd348, 9'd357,
    9'd366, 9'd374, 9'd383, 9'd391, 9'd399, 9'd407, 9'd414, 9'd421,
    9'd428, 9'd435, 9'd441, 9'd448, 9'd454, 9'd459, 9'd465, 9'd470,
    9'd474, 9'd479, 9'd483, 9'd487, 9'd491, 9'd494, 9'd497, 9'd500,
    9'd502, 9'd505, 9'd506, 9'd508, 9'd509, 9'd510, 9'd511, 9'd511
  };

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t               state, state_n;
  logic [PHASE_W-1:0]   phase, tw;
  logic [PHASE_W:0]     sum;
  logic                 carry, legal, xfer_ok;
  logic                 apply_cfg, apply_pend, store_cfg;
  logic [1:0]           active_wave, active_amp;
  logic [7:0]           pend_freq;
  logic [1:0]           pend_wave, pend_amp;

  // The tuning word places freq directly above the 16 fraction bits: f_out = freq kHz.
  assign tw      = {active_freq, {(PHASE_W-8){1'b0}}};
  assign sum     = {1'b0, phase} + {1'b0, tw};
  assign carry   = sum[PHASE_W];
  assign legal   = (cfg_freq <= FMAX);
  assign cfg_ready = (state != PEND);
  assign xfer_ok = cfg_valid & cfg_ready & legal;

  // State register.
  always_ff @(posedge clk_256k or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  // Next state and config-apply decisions.
  always_comb begin
    state_n    = state;
    apply_cfg  = 1'b0;
    apply_pend = 1'b0;
    store_cfg  = 1'b0;
    unique case (state)
      IDLE: begin
        apply_cfg = xfer_ok;
        if (en && ((xfer_ok ? cfg_freq : active_freq) != 8'd0)) state_n = RUN;
      end
      RUN: begin
        if (!en) begin
          // Leaving for IDLE anyway, so a legal request lands immediately.
          apply_cfg = xfer_ok;
          state_n   = IDLE;
        end else if (xfer_ok) begin
          store_cfg = 1'b1;
          state_n   = PEND;
        end
      end
      PEND: begin
        if (!en) begin
          apply_pend = 1'b1;
          state_n    = IDLE;
        end else if (carry) begin
          apply_pend = 1'b1;
          state_n    = (pend_freq == 8'd0) ? IDLE : RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Active and pending configuration registers; error pulse on rejected request.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      active_freq <= '0;
      active_wave <= '0;
      active_amp  <= '0;
      pend_freq   <= '0;
      pend_wave   <= '0;
      pend_amp    <= '0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_valid & cfg_ready & ~legal;
      if (apply_cfg) begin
        active_freq <= cfg_freq;
        active_wave <= cfg_wave;
        active_amp  <= cfg_amp;
      end else if (apply_pend) begin
        active_freq <= pend_freq;
        active_wave <= pend_wave;
        active_amp  <= pend_amp;
      end
      if (store_cfg) begin
        pend_freq <= cfg_freq;
        pend_wave <= cfg_wave;
        pend_amp  <= cfg_amp;
      end
    end
  end

  // Phase accumulator: held at zero in IDLE, keeps the wrapped sum across a retune.
  always_ff @(posedge clk_256k or negedge rst_n)
    if (!rst_n)                                phase <= '0;
    else if (state == IDLE || state_n == IDLE) phase <= '0;
    else                                       phase <= sum[PHASE_W-1:0];

  // Pipeline valid shift register; IDLE flushes in-flight samples.
  logic [STAGES:1] vld_pipe;
  always_ff @(posedge clk_256k or negedge rst_n)
    if (!rst_n)              vld_pipe <= '0;
    else if (state == IDLE)  vld_pipe <= '0;
    else                     vld_pipe <= {vld_pipe[STAGES-1:1], 1'b1};

  assign dac_valid = vld_pipe[STAGES];

  // S1: ROM address (mirrored in odd quadrants), sign, coarse phase, wave and amp.
  logic [5:0] s1_idx;
  logic       s1_neg;
  logic [9:0] s1_p;
  logic [1:0] s1_wave, s1_amp;
  always_ff @(posedge clk_256k or negedge rst_n)
    if (!rst_n) begin
      s1_idx  <= '0;
      s1_neg  <= 1'b0;
      s1_p    <= '0;
      s1_wave <= '0;
      s1_amp  <= '0;
    end else begin
      s1_idx  <= phase[PHASE_W-2] ? ~phase[PHASE_W-3 -: 6] : phase[PHASE_W-3 -: 6];
      s1_neg  <= phase[PHASE_W-1];
      s1_p    <= phase[PHASE_W-1 -: 10];
      s1_wave <= active_wave;
      s1_amp  <= active_amp;
    end

  // Signed sample for the selected waveform.
  logic signed [10:0] wave_s, mag11;
  logic [9:0]         tri_t;
  always_comb begin
    mag11 = {2'b00, SINE_ROM[s1_idx]};
    tri_t = s1_p[9] ? ~{s1_p[8:0], 1'b0} : {s1_p[8:0], 1'b0};
    unique case (s1_wave)
      W_SINE:  wave_s = s1_neg ? -mag11 : mag11;
      W_SQR:   wave_s = s1_p[9] ? -11'sd512 : 11'sd511;
      W_TRI:   wave_s = $signed({1'b0, tri_t}) - 11'sd512;
      default: wave_s = $signed({1'b0, s1_p}) - 11'sd512;
    endcase
  end

  // S2: synchronous ROM read / waveform sample.
  logic signed [10:0] s2_s;
  logic [1:0]         s2_amp;
  always_ff @(posedge clk_256k or negedge rst_n)
    if (!rst_n) begin
      s2_s   <= '0;
      s2_amp <= '0;
    end else begin
      s2_s   <= wave_s;
      s2_amp <= s1_amp;
    end

  // S3: attenuate and re-centre; midscale whenever no live sample is in S2.
  logic signed [10:0] out_s;
  assign out_s = 11'sd512 + (s2_s >>> s2_amp);
  always_ff @(posedge clk_256k or negedge rst_n)
    if (!rst_n)                          dac_data <= 10'd512;
    else if (state == IDLE || !vld_pipe[2]) dac_data <= 10'd512;
    else                                 dac_data <= out_s[9:0];

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: start-up latency, waveform shapes,
// retune at wrap, rejected config, enable drop and reset mid-PEND.
module tb_dds_wave_gen;
  logic       clk_256k = 1'b0;
  logic       rst_n = 1'b0, en = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_freq = '0;
  logic [1:0] cfg_wave = '0, cfg_amp = '0;
  logic       cfg_ready, cfg_err, dac_valid;
  logic [7:0] active_freq;
  logic [9:0] dac_data;

  dds_wave_gen dut (
    .clk_256k(clk_256k), .rst_n(rst_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_freq(cfg_freq), .cfg_wave(cfg_wave), .cfg_amp(cfg_amp),
    .cfg_err(cfg_err), .active_freq(active_freq),
    .dac_data(dac_data), .dac_valid(dac_valid)
  );

  always #5 clk_256k = ~clk_256k;

  int n_chk = 0, n_err = 0;
  int sq0 [4] = '{1023, 1023, 0, 0};
  int sq1 [4] = '{767, 767, 256, 256};
  int trw [4] = '{0, 512, 1023, 511};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_256k);
    #1;
  endtask

  task automatic send(input int f, input int w, input int a);
    cfg_valid = 1'b1;
    cfg_freq  = 8'(f);
    cfg_wave  = 2'(w);
    cfg_amp   = 2'(a);
    step();
    cfg_valid = 1'b0;
  endtask

  // Force IDLE, then start with a fresh config; returns on the first valid sample.
  task automatic start(input int f, input int w, input int a);
    en = 1'b0;
    step(2);
    en = 1'b1;
    send(f, w, a);
    step(3);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data"},  32'(dac_data), 512);
    chk({tag, "_valid"}, 32'(dac_valid), 0);
    chk({tag, "_ready"}, 32'(cfg_ready), 1);
    chk({tag, "_err"},   32'(cfg_err), 0);
    chk({tag, "_freq"},  32'(active_freq), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int mn, mx, n, rdy_hi, vld_lo;

    // Reset state
    step(2);
    chk_reset("rst");
    rst_n = 1'b1;
    step(2);
    chk("idle_valid", 32'(dac_valid), 0);

    // freq 1 sine: latency, shape and period
    en = 1'b1;
    send(1, 0, 0);
    chk("start_freq", 32'(active_freq), 1);
    step(2);
    chk("pre_valid", 32'(dac_valid), 0);
    step(1);
    chk("first_valid", 32'(dac_valid), 1);
    chk("first_sine", 32'(dac_data), 518);
    mn = 518; mx = 518; vld_lo = 0;
    for (int k = 1; k <= 256; k++) begin
      step();
      if (!dac_valid) vld_lo++;
      if (k < 256) begin
        if (int'(dac_data) < mn) mn = int'(dac_data);
        if (int'(dac_data) > mx) mx = int'(dac_data);
      end
      if (k == 64)  chk("sine_64", 32'(dac_data), 1023);
      if (k == 128) chk("sine_128", 32'(dac_data), 506);
      if (k == 192) chk("sine_192", 32'(dac_data), 1);
      if (k == 256) chk("sine_256", 32'(dac_data), 518);
    end
    chk("sine_max", 32'(mx), 1023);
    chk("sine_min", 32'(mn), 1);
    chk("sine_vld_gaps", 32'(vld_lo), 0);

    // freq 64 square, amp 0 and 1; triangle
    start(64, 1, 0);
    for (int k = 0; k < 8; k++) begin chk("sq_amp0", 32'(dac_data), 32'(sq0[k % 4])); step(); end
    start(64, 1, 1);
    for (int k = 0; k < 8; k++) begin chk("sq_amp1", 32'(dac_data), 32'(sq1[k % 4])); step(); end
    start(64, 2, 0);
    for (int k = 0; k < 8; k++) begin chk("tri", 32'(dac_data), 32'(trw[k % 4])); step(); end

    // Retune freq 1 -> 2 requested at phase index 100, applied at the wrap
    start(1, 0, 0);
    step(97);
    chk("req_ready", 32'(cfg_ready), 1);
    send(2, 0, 0);
    chk("pend_ready", 32'(cfg_ready), 0);
    chk("pend_freq", 32'(active_freq), 1);
    n = 0; rdy_hi = 0;
    while (active_freq != 8'd2 && n < 400) begin
      if (cfg_ready) rdy_hi++;
      step();
      n++;
    end
    chk("wrap_cycles", 32'(n), 155);
    chk("pend_ready_hi", 32'(rdy_hi), 0);
    chk("post_ready", 32'(cfg_ready), 1);
    step(2);
    chk("pre_wrap", 32'(dac_data), 506);
    step(1);
    chk("wrap", 32'(dac_data), 518);
    step(32);
    chk("f2_32", 32'(dac_data), 1023);
    step(32);
    chk("f2_64", 32'(dac_data), 506);
    step(64);
    chk("f2_period", 32'(dac_data), 518);

    // Out-of-range request: one-cycle error, nothing changes
    send(101, 1, 3);
    chk("err_pulse", 32'(cfg_err), 1);
    chk("err_freq", 32'(active_freq), 2);
    chk("err_ready", 32'(cfg_ready), 1);
    step();
    chk("err_clear", 32'(cfg_err), 0);
    step(62);
    chk("err_output", 32'(dac_data), 506);

    // en dropped mid-period, then raised again
    en = 1'b0;
    step(2);
    chk("endrop_valid", 32'(dac_valid), 0);
    chk("endrop_data", 32'(dac_data), 512);
    chk("endrop_ready", 32'(cfg_ready), 1);
    en = 1'b1;
    step(3);
    chk("reen_pre", 32'(dac_valid), 0);
    step(1);
    chk("reen_valid", 32'(dac_valid), 1);
    chk("reen_data", 32'(dac_data), 518);

    // Reset asserted while a config is pending
    send(3, 1, 0);
    chk("h_pend_ready", 32'(cfg_ready), 0);
    step(5);
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    step();
    rst_n = 1'b1;
    step(3);
    chk_reset("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dds_wave_gen.md
# dds_wave_gen

Direct-digital-synthesis test-signal source, the transmit counterpart of the frequency-measurement chain. It produces a 10-bit offset-binary DAC sample stream at the clk_256k sample rate (Fs = 256 000 Hz). The output frequency is set in whole kHz using the same 8-bit code the measurement path reports, so one board can loop generator to ADC and self-check. Configuration is taken over a valid/ready handshake and applied glitch-free at the next phase wrap.

## Interface
- PHASE_W, 24, phase accumulator width; tuning word = {freq, 16'b0} (exact: f_out = freq × 1 kHz)
- FREQ_MAX, 100, largest legal freq code (kHz); must stay < 128 (Nyquist)
- clk_256k  in  1  sample clock; reset rst_n, asynchronous, active-low; clock clk_256k
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level enable; low forces IDLE
- cfg_valid  in  1  config request
- cfg_ready  out  1  config can be accepted
- cfg_freq  in  8  output frequency, kHz, 0..FREQ_MAX
- cfg_wave  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth
- cfg_amp  in  2  amplitude attenuation, arithmetic right shift of the signed sample by 0..3
- cfg_err  out  1  one-cycle pulse: accepted request had cfg_freq > FREQ_MAX
- active_freq  out  8  frequency code currently driving the phase accumulator
- dac_data  out  10  offset-binary sample; midscale 512
- dac_valid  out  1  dac_data is a live sample

## Operation
- States:
  - IDLE: phase = 0; pipeline valid cleared; dac_data = 512.
  - RUN: accumulator advances every cycle.
  - PEND: running with a stored config waiting for a wrap.
- Handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - cfg_ready = 1 in IDLE and RUN, 0 in PEND.
  - cfg_err pulses with a rejected request; the rejected request is consumed and all settings are unchanged.
- Config application:
  - IDLE: apply a legal config immediately.
  - RUN: store the config and go to PEND.
  - PEND: apply in the cycle where phase + tw carries out of PHASE_W bits. The new tw takes effect from the next addition. The phase keeps (sum mod 2^PHASE_W), so there is no discontinuity.
- freq 0 is legal. Applying it sets active_freq = 0 and goes to IDLE.
- State transitions:
  - IDLE → RUN when en = 1 and active_freq ≠ 0. The first RUN phase is 0.
  - en = 0 in any state → IDLE next cycle. A pending config is applied on entry to IDLE.
- Waveform, from phase p = phase[23:14] (10 bits):
  - Sine: quarter-wave ROM of 64 entries × 9 bits, mag[i] = round(511·sin(π/2·(i+0.5)/64)). Index = phase[21:16], mirrored (~index) in quadrants 1 and 3. Signed sample s = +mag in quadrants 0–1, −mag in quadrants 2–3.
  - Square: s = +511 if phase[23] = 0, else −512.
  - Triangle: t = p[9] ? ~{p[8:0],0} : {p[8:0],0}; s = t − 512.
  - Sawtooth: s = p − 512.
- Output: dac_data = 512 + (s >>> amp), computed in 11-bit signed and always within 0..1023.
- cfg_wave and cfg_amp travel down the pipeline with their phase sample, so a switch lands exactly on the wrap sample.

## Timing
- Reset values: state IDLE, phase 0, active_freq 0, dac_data 512, dac_valid 0, cfg_ready 1, cfg_err 0. Stored config cleared.
- Pipeline:
  - S1 registers ROM address, sign, wave and amp.
  - S2 is the synchronous ROM read, which yields s.
  - S3 registers dac_data.
- dac_data corresponds to the phase from 3 cycles earlier. dac_valid is the 3-stage delayed copy of (state ≠ IDLE).
- Timing of a start from IDLE:
  - Handshake at cycle T.
  - RUN with phase 0 at T+1.
  - First valid dac_data at T+4.
- en falling at cycle T:
  - IDLE at T+1.
  - dac_valid = 0 and dac_data = 512 from T+2; in-flight samples are discarded.
- Maximum PEND dwell is 2^24 / tw ≤ 256 cycles, since freq ≥ 1 while running.
- Reset mid-operation: everything returns to reset values at once; no partial config survives.

## Test plan
- freq 1, sine, amp 0, en 1:
  - First valid sample = 518 (mag[0] = 6).
  - Period 256 samples, max 1023, min 1.
  - Sample 128 after start ≈ 506.
- freq 64, square, amp 0: repeating 1023, 1023, 0, 0. With amp 1: 767, 767, 256, 256.
- freq 64, triangle: samples 0, 512, 1023, 511, repeating.
- Running freq 1, request freq 2 at sample 100:
  - cfg_ready low until the wrap.
  - active_freq changes to 2 at sample 256.
  - No discontinuity; the next period is 128 samples.
- Request freq 101:
  - cfg_err is high for exactly 1 cycle.
  - active_freq and the output are unchanged.
  - cfg_ready stays 1.
- en dropped mid-period: dac_valid = 0 and dac_data = 512 two cycles later. en raised again: first valid sample (518 for sine) 3 cycles after RUN entry. Also assert rst_n mid-PEND and check all reset values.
